ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the NPC core, directly upstream of the decode stage. Holds the architectural PC, issues one instruction-memory read per instruction over a valid/ready request/response bus, and presents the fetched word to decode with an `IFU_done` handshake. Execution is non-overlapped: after decode accepts an instruction, the unit waits for the next-PC update from the commit path before fetching again.

## Interface
- `RESET_PC`, 32'h8000_0000, PC loaded on reset
- `NOP_INST`, 32'h0000_0013, word presented on a faulting fetch
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `mem_req_valid`  out  1  fetch request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  32  fetch address, equals `pc`
- `mem_rsp_valid`  in  1  read data valid
- `mem_rsp_data`  in  32  instruction word
- `mem_rsp_err`  in  1  bus error on this response
- `IFU_done`  out  1  `instruction`/`pc`/`fetch_fault` valid to decode
- `IDU_ready`  in  1  decode accepts current instruction
- `instruction`  out  32  fetched word
- `pc`  out  32  PC of `instruction`
- `fetch_fault`  out  1  misaligned PC or bus error on this fetch
- `pc_upd_valid`  in  1  next PC available from commit
- `pc_upd_target`  in  32  next PC
- `fetch_cnt`  out  32  instructions handed to decode since reset

## Operation
- States: IDLE, REQ, RSP, ISSUE, WAIT_PC.
- IDLE: reset state; unconditionally to REQ next cycle.
- REQ: if `pc[1:0]!=0`: no bus request; latch `instruction=NOP_INST`, `fetch_fault=1`; to ISSUE. Else `mem_req_valid=1`, `mem_req_addr=pc`, held stable until `mem_req_ready`; on handshake to RSP.
- RSP: on `mem_rsp_valid` latch `instruction=mem_rsp_err?NOP_INST:mem_rsp_data`, `fetch_fault=mem_rsp_err`; to ISSUE.
- ISSUE: `IFU_done=1`; outputs held stable until `IDU_ready`. On `IFU_done&IDU_ready`: `fetch_cnt` increments (wraps 2^32-1 -> 0); to WAIT_PC.
- WAIT_PC: on `pc_upd_valid` load `pc=pc_upd_target`; to REQ.
- `mem_rsp_valid` outside RSP and `pc_upd_valid` outside WAIT_PC are ignored; `IDU_ready` outside ISSUE has no effect.
- Exactly one outstanding bus request; memory and IFU reset together, so no stale response survives reset.

## Timing
- Reset (async assert): `pc=RESET_PC`, state IDLE, `mem_req_valid=0`, `IFU_done=0`, `instruction=NOP_INST`, `fetch_fault=0`, `fetch_cnt=0`. Outputs registered, none combinational from inputs.
- First request: `mem_req_valid` high in 2nd cycle after `rst_n` deasserts.
- Zero-wait memory (`mem_req_ready=1`, rsp one cycle later): request cycle N, response N+1, `IFU_done` high N+2, accepted same cycle if `IDU_ready=1`; `pc_upd_valid` at N+3 gives next request at N+4. Min 4 cycles/instruction.
- Misaligned PC: REQ -> ISSUE in one cycle, no bus activity.
- `IFU_done` deasserts the cycle after acceptance.
- Reset mid-transaction: state and outputs return to reset values immediately; fetch restarts at `RESET_PC`.

## Structure
- Shared package `npc_pkg`: state enum `ifu_state_t`, `NOP_INST`, `RESET_PC_DEFAULT`, `XLEN=32`.
- Single module; FSM, PC register and output latches inline. `fetch_cnt` may be split into sub-module `ifu_perf_cnt` (enable, wrap counter) for reuse by other stages.

## Test plan
- Reset release, zero-wait memory returning 32'h00100093 at 8000_0000 -> `mem_req_addr`=8000_0000 in cycle 2, `IFU_done` cycle 4 with `pc`=8000_0000, `instruction`=00100093.
- `mem_req_ready` low 3 cycles, `IDU_ready` low 2 cycles -> `mem_req_addr`/`instruction` stable throughout, single handshake each, `fetch_cnt` 0 -> 1.
- `pc_upd_target`=8000_0102 -> no request, `IFU_done` with `fetch_fault=1`, `instruction`=00000013, `pc`=8000_0102.
- `mem_rsp_err=1` at 8000_0004 -> `fetch_fault=1`, `instruction`=00000013; next fetch after `pc_upd` clean, `fetch_fault=0`.
- Spurious `mem_rsp_valid` in WAIT_PC and `pc_upd_valid` in RSP -> ignored, state/PC unchanged.
- `rst_n` low while in RSP -> all outputs to reset values same cycle; restart fetches 8000_0000.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core: data width, reset PC, canonical NOP
// and the fetch-unit state encoding.
package npc_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [2:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_RSP,
    IFU_ISSUE,
    IFU_WAIT_PC
  } ifu_state_t;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Free-running event counter with enable; wraps naturally at 2^WIDTH.
module ifu_perf_cnt
  import npc_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Non-overlapped instruction fetch: one bus read per instruction, hand-off to
// decode, then wait for the commit path to supply the next PC.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            IFU_done,
  input  logic            IDU_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic            fetch_fault,
  input  logic            pc_upd_valid,
  input  logic [XLEN-1:0] pc_upd_target,
  output logic [XLEN-1:0] fetch_cnt
);

  ifu_state_t state_q, state_d;
  logic       misaligned;

  assign misaligned = (pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus and decode strobes decode only from registered state, never from inputs.
  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    IFU_done      = 1'b0;
    unique case (state_q)
      IFU_IDLE: state_d = IFU_REQ;
      IFU_REQ: begin
        if (misaligned) begin
          state_d = IFU_ISSUE;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) state_d = IFU_RSP;
        end
      end
      IFU_RSP: if (mem_rsp_valid) state_d = IFU_ISSUE;
      IFU_ISSUE: begin
        IFU_done = 1'b1;
        if (IDU_ready) state_d = IFU_WAIT_PC;
      end
      IFU_WAIT_PC: if (pc_upd_valid) state_d = IFU_REQ;
      default: state_d = IFU_IDLE;
    endcase
  end

  assign mem_req_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instruction <= NOP_INST;
      fetch_fault <= 1'b0;
    end else begin
      if (state_q == IFU_REQ && misaligned) begin
        instruction <= NOP_INST;
        fetch_fault <= 1'b1;
      end
      if (state_q == IFU_RSP && mem_rsp_valid) begin
        instruction <= mem_rsp_err ? NOP_INST : mem_rsp_data;
        fetch_fault <= mem_rsp_err;
      end
      if (state_q == IFU_WAIT_PC && pc_upd_valid) begin
        pc <= pc_upd_target;
      end
    end
  end

  ifu_perf_cnt #(
    .WIDTH(XLEN)
  ) u_fetch_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (IFU_done && IDU_ready),
    .count(fetch_cnt)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: plays memory and decode cycle by cycle, checking each
// hand-off against a transaction-level model of the fetch rules.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        IFU_done;
  logic        IDU_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        fetch_fault;
  logic        pc_upd_valid;
  logic [31:0] pc_upd_target;
  logic [31:0] fetch_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_err  (mem_rsp_err),
    .IFU_done     (IFU_done),
    .IDU_ready    (IDU_ready),
    .instruction  (instruction),
    .pc           (pc),
    .fetch_fault  (fetch_fault),
    .pc_upd_valid (pc_upd_valid),
    .pc_upd_target(pc_upd_target),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not terminate");
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          err;
    int unsigned req_stall;
    int unsigned rsp_delay;
    int unsigned idu_stall;
    bit          spurious;
    logic [31:0] exp_instr;
    bit          exp_fault;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fetch rule: misaligned PC or bus error yields a faulting NOP, else the word.
  function automatic logic [32:0] model_fetch(input logic [31:0] a, input logic [31:0] d,
                                              input bit e);
    if (a % 4 != 0 || e) return {1'b1, NOP};
    return {1'b0, d};
  endfunction

  task automatic idle_inputs();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    IDU_ready     = 1'b0;
    pc_upd_valid  = 1'b0;
    pc_upd_target = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    check({tag, "_done"}, {31'd0, IFU_done}, 32'd0);
    check({tag, "_pc"}, pc, RST_PC);
    check({tag, "_instr"}, instruction, NOP);
    check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    check({tag, "_cnt"}, fetch_cnt, 32'd0);
  endtask

  // Entered at a falling edge with the DUT in IDLE right after reset release.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_no_req", {31'd0, mem_req_valid}, 32'd0);
    exp_cnt = 32'd0;
    @(negedge clk);
  endtask

  // Entered at a falling edge where the DUT must be presenting the REQ for epc.
  task automatic do_fetch(input vec_t v, input logic [31:0] next_pc);
    check("pc_at_req", pc, v.pc);
    if (v.pc[1:0] != 2'b00) begin
      check("misaligned_no_req", {31'd0, mem_req_valid}, 32'd0);
      step();
    end else begin
      for (int unsigned i = 0; i < v.req_stall; i++) begin
        mem_req_ready = 1'b0;
        check("req_valid_stall", {31'd0, mem_req_valid}, 32'd1);
        check("req_addr_stall", mem_req_addr, v.pc);
        step();
      end
      check("req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("req_addr", mem_req_addr, v.pc);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      check("req_single", {31'd0, mem_req_valid}, 32'd0);
      for (int unsigned i = 0; i < v.rsp_delay; i++) begin
        if (v.spurious) begin
          pc_upd_valid  = 1'b1;
          pc_upd_target = $urandom;
        end
        check("done_early", {31'd0, IFU_done}, 32'd0);
        step();
        pc_upd_valid = 1'b0;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = v.data;
      mem_rsp_err   = v.err;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      mem_rsp_data  = $urandom;
    end
    check("done", {31'd0, IFU_done}, 32'd1);
    check("instr", instruction, v.exp_instr);
    check("fault", {31'd0, fetch_fault}, {31'd0, v.exp_fault});
    check("pc_issue", pc, v.pc);
    for (int unsigned i = 0; i < v.idu_stall; i++) begin
      IDU_ready = 1'b0;
      step();
      check("done_hold", {31'd0, IFU_done}, 32'd1);
      check("instr_hold", instruction, v.exp_instr);
      check("cnt_hold", fetch_cnt, exp_cnt);
    end
    IDU_ready = 1'b1;
    step();
    IDU_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    check("done_drop", {31'd0, IFU_done}, 32'd0);
    check("fetch_cnt", fetch_cnt, exp_cnt);
    if (v.spurious) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
      step();
      mem_rsp_valid = 1'b0;
      check("spur_rsp_noreq", {31'd0, mem_req_valid}, 32'd0);
      check("spur_rsp_done", {31'd0, IFU_done}, 32'd0);
      check("spur_rsp_pc", pc, v.pc);
      check("spur_rsp_instr", instruction, v.exp_instr);
    end
    pc_upd_valid  = 1'b1;
    pc_upd_target = next_pc;
    step();
    pc_upd_valid  = 1'b0;
  endtask

  vec_t vecs[7];
  vec_t rv;
  vec_t nv;
  logic [32:0] m;

  initial begin
    vecs[0] = '{32'h8000_0000, 32'h0010_0093, 1'b0, 0, 0, 0, 1'b0, 32'h0010_0093, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'h0020_0113, 1'b0, 3, 0, 2, 1'b0, 32'h0020_0113, 1'b0};
    vecs[2] = '{32'h8000_0102, 32'hdead_beef, 1'b0, 0, 0, 0, 1'b0, 32'h0000_0013, 1'b1};
    vecs[3] = '{32'h8000_0004, 32'h1234_5678, 1'b1, 0, 1, 0, 1'b0, 32'h0000_0013, 1'b1};
    vecs[4] = '{32'h8000_0008, 32'h0030_0193, 1'b0, 0, 2, 0, 1'b1, 32'h0030_0193, 1'b0};
    vecs[5] = '{32'h8000_0011, 32'h0000_0000, 1'b0, 0, 0, 1, 1'b0, 32'h0000_0013, 1'b1};
    vecs[6] = '{32'h8000_000c, 32'hffff_ffff, 1'b0, 1, 1, 1, 1'b1, 32'hffff_ffff, 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    release_reset();

    for (int i = 0; i < 7; i++) begin
      do_fetch(vecs[i], (i < 6) ? vecs[i+1].pc : 32'h8000_1000);
    end

    nv.pc = 32'h8000_1000;
    for (int i = 0; i < 40; i++) begin
      rv = nv;
      rv.data      = $urandom;
      rv.err       = ($urandom_range(0, 4) == 0);
      rv.req_stall = $urandom_range(0, 3);
      rv.rsp_delay = $urandom_range(0, 3);
      rv.idu_stall = $urandom_range(0, 3);
      rv.spurious  = $urandom_range(0, 1) == 1;
      m = model_fetch(rv.pc, rv.data, rv.err);
      rv.exp_fault = m[32];
      rv.exp_instr = m[31:0];
      nv.pc = $urandom;
      if ($urandom_range(0, 3) != 0) nv.pc[1:0] = 2'b00;
      do_fetch(rv, nv.pc);
    end

    // Reset asserted asynchronously while a response is outstanding.
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("pre_reset_in_rsp", {31'd0, mem_req_valid}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    release_reset();
    do_fetch('{32'h8000_0000, 32'h0040_0213, 1'b0, 0, 0, 0, 1'b0, 32'h0040_0213, 1'b0},
             32'h8000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
